// File: rtl/spi_adder_pkg.sv
// Shared types and frame layout for the SPI front end of the 4-bit adder.
package spi_adder_pkg;

  localparam int FRAME_BITS = 16;
  localparam int A_MSB      = 15;
  localparam int B_MSB      = 11;
  localparam int CIN_BIT    = 7;
  localparam int OPND_W     = 4;
  localparam int SUM_W      = 5;
  localparam int CNT_W      = 8;
  localparam int BIT_CNT_W  = 5;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LATCH,
    CAPTURE,
    DONE
  } state_t;

  // Reply word returned to the host: zero pad, adder sum, frame counter.
  function automatic logic [FRAME_BITS-1:0] tx_word(input logic [SUM_W-1:0] sum,
                                                    input logic [CNT_W-1:0] cnt);
    return {{(FRAME_BITS-SUM_W-CNT_W){1'b0}}, sum, cnt};
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived from the synchronized value (one clk cycle wide each).
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_sr;
  logic              q_d;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr <= {STAGES{RST_VAL}};
      q_d     <= RST_VAL;
    end else begin
      sync_sr <= {sync_sr[STAGES-2:0], d};
      q_d     <= sync_sr[STAGES-1];
    end
  end

  assign q    = sync_sr[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_adder_link.sv
// SPI mode-0 slave that loads operands into the ripple adder and returns the
// captured sum (plus a frame counter) to the host during the following frame.
module spi_adder_link
  import spi_adder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic [OPND_W-1:0] op_a,
  output logic [OPND_W-1:0] op_b,
  output logic             op_cin,
  output logic             op_valid,
  input  logic [SUM_W-1:0] sum_in,
  output logic [SUM_W-1:0] result,
  output logic             result_valid,
  output logic             frame_err
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic mosi_s;

  state_t                 state;
  logic [FRAME_BITS-2:0]  rx_sr;
  logic [FRAME_BITS-1:0]  rx_next;
  logic [FRAME_BITS-1:0]  tx_sr;
  logic [FRAME_BITS-1:0]  tx_shadow;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt_inc;
  logic [CNT_W-1:0]       frame_cnt;

  // SCLK idles low in mode 0, CS_N idles high; reset values match so no
  // spurious edge is seen when reset releases.
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (spi_sclk),
    .q    (sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (spi_cs_n),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // Level-only synchronizers' spare outputs.
  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_q, cs_rise};

  // MOSI gets the same depth as SCLK so data and its sampling edge stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sr <= '0;
    else        mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  assign rx_next     = {rx_sr, mosi_s};
  assign bit_cnt_inc = (bit_cnt == LAST_BIT) ? bit_cnt : bit_cnt + 1'b1;

  // MISO comes straight off the shift register so bit 15 is on the wire
  // within a cycle of the synchronized CS_N fall, well ahead of the first rise.
  assign spi_miso = (state == SHIFT) & tx_sr[FRAME_BITS-1];

  // Frame FSM. Strobes are registered and raised on the transition into the
  // state they belong to: op_valid is high while in LATCH, result_valid while
  // in CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rx_sr        <= '0;
      tx_sr        <= '0;
      tx_shadow    <= '0;
      bit_cnt      <= '0;
      frame_cnt    <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_cin       <= 1'b0;
      op_valid     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      op_valid     <= 1'b0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            tx_sr   <= tx_shadow;
            rx_sr   <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_q) begin
            // Host released CS_N before the last bit: drop the frame.
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            if (sclk_fall) tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
            if (sclk_rise) begin
              rx_sr   <= rx_next[FRAME_BITS-2:0];
              bit_cnt <= bit_cnt_inc;
              if (bit_cnt_inc == LAST_BIT) begin
                op_a     <= rx_next[A_MSB -: OPND_W];
                op_b     <= rx_next[B_MSB -: OPND_W];
                op_cin   <= rx_next[CIN_BIT];
                op_valid <= 1'b1;
                state    <= LATCH;
              end
            end
          end
        end
        LATCH: begin
          // sum_in has settled from the operands registered last cycle.
          result       <= sum_in;
          result_valid <= 1'b1;
          tx_shadow    <= tx_word(sum_in, frame_cnt + 8'd1);
          frame_cnt    <= frame_cnt + 8'd1;
          state        <= CAPTURE;
        end
        CAPTURE: state <= DONE;
        DONE: begin
          // Trailing SCLK pulses are ignored; wait for the host to end the frame.
          if (cs_q) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
